// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - prescaled up / up-down PWM timebase with double-buffered period settings
module pwm_timebase #(
    parameter int WIDTH = 7,
    parameter int PSW   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] top_i,
    input  logic [PSW-1:0]   prescale_i,
    output logic [WIDTH-1:0] tcr_o,
    output logic             e_o,
    output logic             pk_o,
    output logic             dir_o
);

    logic [WIDTH-1:0] tcr_q, tcr_d;
    logic [WIDTH-1:0] top_s_q, top_s_d;
    logic [PSW-1:0]   pcnt_q, pcnt_d;
    logic [PSW-1:0]   pre_s_q, pre_s_d;
    logic             mode_s_q, mode_s_d;
    logic             dir_q, dir_d;
    logic             e_q, e_d;
    logic             pk_q, pk_d;

    logic             tick;
    logic             wrap;
    logic             peak;
    logic [WIDTH-1:0] cnt_nxt;
    logic             dir_nxt;

    // Count/direction that the next tick would produce under the active shadow settings.
    always_comb begin
        cnt_nxt = tcr_q;
        dir_nxt = dir_q;
        if (!mode_s_q) begin
            dir_nxt = 1'b1;
            if (tcr_q >= top_s_q) begin
                cnt_nxt = '0;
            end else begin
                cnt_nxt = tcr_q + WIDTH'(1);
            end
        end else if ((tcr_q > top_s_q) || (top_s_q == '0)) begin
            cnt_nxt = '0;
            dir_nxt = 1'b1;
        end else if (dir_q) begin
            if (tcr_q == top_s_q) begin
                // With TOP_s==1 the turnaround lands on 0, so counting up resumes immediately.
                cnt_nxt = top_s_q - WIDTH'(1);
                dir_nxt = (top_s_q == WIDTH'(1));
            end else begin
                cnt_nxt = tcr_q + WIDTH'(1);
                dir_nxt = 1'b1;
            end
        end else if (tcr_q <= WIDTH'(1)) begin
            cnt_nxt = '0;
            dir_nxt = 1'b1;
        end else begin
            cnt_nxt = tcr_q - WIDTH'(1);
            dir_nxt = 1'b0;
        end
    end

    assign tick = (pcnt_q == pre_s_q);
    assign wrap = (cnt_nxt == '0) && ((tcr_q != '0) || (tcr_q == top_s_q));
    assign peak = (cnt_nxt == top_s_q);

    always_comb begin
        tcr_d    = tcr_q;
        dir_d    = dir_q;
        pcnt_d   = pcnt_q;
        top_s_d  = top_s_q;
        pre_s_d  = pre_s_q;
        mode_s_d = mode_s_q;
        e_d      = 1'b0;
        pk_d     = 1'b0;
        if (clr_i) begin
            tcr_d    = '0;
            dir_d    = 1'b1;
            pcnt_d   = '0;
            e_d      = 1'b1;
            top_s_d  = top_i;
            pre_s_d  = prescale_i;
            mode_s_d = mode_i;
        end else if (!en_i) begin
            top_s_d  = top_i;
            pre_s_d  = prescale_i;
            mode_s_d = mode_i;
        end else if (tick) begin
            pcnt_d = '0;
            tcr_d  = cnt_nxt;
            dir_d  = dir_nxt;
            e_d    = wrap;
            pk_d   = peak;
            if (wrap) begin
                top_s_d  = top_i;
                pre_s_d  = prescale_i;
                mode_s_d = mode_i;
            end
        end else begin
            pcnt_d = pcnt_q + PSW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tcr_q    <= '0;
            dir_q    <= 1'b1;
            pcnt_q   <= '0;
            e_q      <= 1'b0;
            pk_q     <= 1'b0;
            top_s_q  <= '1;
            pre_s_q  <= '0;
            mode_s_q <= 1'b0;
        end else begin
            tcr_q    <= tcr_d;
            dir_q    <= dir_d;
            pcnt_q   <= pcnt_d;
            e_q      <= e_d;
            pk_q     <= pk_d;
            top_s_q  <= top_s_d;
            pre_s_q  <= pre_s_d;
            mode_s_q <= mode_s_d;
        end
    end

    assign tcr_o = tcr_q;
    assign e_o   = e_q;
    assign pk_o  = pk_q;
    assign dir_o = dir_q;

endmodule

// File: tb/tb_pwm_timebase.sv
// tb/tb_pwm_timebase.sv - directed self-checking bench for pwm_timebase
module tb_pwm_timebase;
    localparam int W = 7;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         rst, en, clr, mode;
    logic [W-1:0] top;
    logic [P-1:0] pre;
    logic [W-1:0] tcr;
    logic         e, pk, dir;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    pwm_timebase #(.WIDTH(W), .PSW(P)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .mode_i(mode),
        .top_i(top), .prescale_i(pre),
        .tcr_o(tcr), .e_o(e), .pk_o(pk), .dir_o(dir)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 1'b0; top = 7'd4; pre = 4'd0;
        step(); step();
        checks++; if (tcr !== 7'd0) begin errors++; $display("FAIL reset_tcr: got %0d expected 0", tcr); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL reset_e: got %b expected 0", e); end
        checks++; if (pk !== 1'b0) begin errors++; $display("FAIL reset_pk: got %b expected 0", pk); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL reset_dir: got %b expected 1", dir); end
        rst = 1'b0;
    endtask

    task automatic test_up();
        int exp;
        en = 1'b0; mode = 1'b0; top = 7'd4; pre = 4'd0;
        step();
        checks++; if (tcr !== 7'd0 || e !== 1'b0) begin errors++; $display("FAIL up_pause: got tcr=%0d e=%b expected tcr=0 e=0", tcr, e); end
        en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp = i % 5;
            checks++; if (tcr !== W'(exp)) begin errors++; $display("FAIL up_tcr[%0d]: got %0d expected %0d", i, tcr, exp); end
            checks++; if (e !== (exp == 0)) begin errors++; $display("FAIL up_e[%0d]: got %b expected %b", i, e, exp == 0); end
            checks++; if (pk !== (exp == 4)) begin errors++; $display("FAIL up_pk[%0d]: got %b expected %b", i, pk, exp == 4); end
        end
    endtask

    task automatic test_updown();
        int exp_t[6] = '{1, 2, 3, 2, 1, 0};
        int exp_d[6] = '{1, 1, 1, 0, 0, 1};
        int k;
        en = 1'b0; mode = 1'b1; top = 7'd3; pre = 4'd0; clr = 1'b1;
        step();
        checks++; if (tcr !== 7'd0 || e !== 1'b1 || dir !== 1'b1) begin errors++; $display("FAIL ud_clr: got tcr=%0d e=%b dir=%b expected 0 1 1", tcr, e, dir); end
        clr = 1'b0; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            k = i % 6;
            checks++; if (tcr !== W'(exp_t[k])) begin errors++; $display("FAIL ud_tcr[%0d]: got %0d expected %0d", i, tcr, exp_t[k]); end
            checks++; if (dir !== exp_d[k][0]) begin errors++; $display("FAIL ud_dir[%0d]: got %b expected %0d", i, dir, exp_d[k]); end
            checks++; if (e !== (exp_t[k] == 0)) begin errors++; $display("FAIL ud_e[%0d]: got %b expected %b", i, e, exp_t[k] == 0); end
            checks++; if (pk !== (exp_t[k] == 3)) begin errors++; $display("FAIL ud_pk[%0d]: got %b expected %b", i, pk, exp_t[k] == 3); end
        end
    endtask

    task automatic test_prescale();
        int exp;
        en = 1'b0; mode = 1'b0; top = 7'd2; pre = 4'd2; clr = 1'b1;
        step();
        clr = 1'b0; en = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            exp = (k / 3) % 3;
            checks++; if (tcr !== W'(exp)) begin errors++; $display("FAIL ps_tcr[%0d]: got %0d expected %0d", k, tcr, exp); end
            checks++; if (e !== (k % 9 == 0)) begin errors++; $display("FAIL ps_e[%0d]: got %b expected %b", k, e, k % 9 == 0); end
            checks++; if (pk !== (k % 9 == 6)) begin errors++; $display("FAIL ps_pk[%0d]: got %b expected %b", k, pk, k % 9 == 6); end
        end
    endtask

    task automatic test_top_change();
        int exp_t[8] = '{4, 5, 6, 7, 0, 1, 2, 0};
        en = 1'b0; mode = 1'b0; top = 7'd7; pre = 4'd0; clr = 1'b1;
        step();
        clr = 1'b0; en = 1'b1;
        step(); step(); step();
        checks++; if (tcr !== 7'd3) begin errors++; $display("FAIL tc_start: got %0d expected 3", tcr); end
        top = 7'd2;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (tcr !== W'(exp_t[i])) begin errors++; $display("FAIL tc_tcr[%0d]: got %0d expected %0d", i, tcr, exp_t[i]); end
            checks++; if (e !== (exp_t[i] == 0)) begin errors++; $display("FAIL tc_e[%0d]: got %b expected %b", i, e, exp_t[i] == 0); end
        end
    endtask

    task automatic test_reset_mid();
        en = 1'b0; mode = 1'b0; top = 7'd7; pre = 4'd0; clr = 1'b1;
        step();
        clr = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++; if (tcr !== 7'd5) begin errors++; $display("FAIL rm_pre: got %0d expected 5", tcr); end
        rst = 1'b1;
        step();
        checks++; if (tcr !== 7'd0 || e !== 1'b0 || dir !== 1'b1 || pk !== 1'b0) begin errors++; $display("FAIL rm_rst: got tcr=%0d e=%b dir=%b pk=%b expected 0 0 1 0", tcr, e, dir, pk); end
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++; if (tcr !== W'(i) || e !== 1'b0) begin errors++; $display("FAIL rm_run[%0d]: got tcr=%0d e=%b expected %0d 0", i, tcr, e, i); end
        end
        en = 1'b0;
        step();
        checks++; if (tcr !== 7'd10 || e !== 1'b0 || pk !== 1'b0) begin errors++; $display("FAIL rm_hold: got tcr=%0d e=%b pk=%b expected 10 0 0", tcr, e, pk); end
        en = 1'b1;
        step();
        checks++; if (tcr !== 7'd0 || e !== 1'b1) begin errors++; $display("FAIL rm_wrap: got tcr=%0d e=%b expected 0 1", tcr, e); end
    endtask

    task automatic test_top_zero();
        logic t;
        en = 1'b0; mode = 1'b0; top = 7'd0; pre = 4'd1; clr = 1'b1;
        step();
        checks++; if (tcr !== 7'd0 || e !== 1'b1 || pk !== 1'b0) begin errors++; $display("FAIL tz_clr: got tcr=%0d e=%b pk=%b expected 0 1 0", tcr, e, pk); end
        clr = 1'b0; en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            t = (k % 2 == 0);
            checks++; if (tcr !== 7'd0 || e !== t || pk !== t) begin errors++; $display("FAIL tz_run[%0d]: got tcr=%0d e=%b pk=%b expected 0 %b %b", k, tcr, e, pk, t, t); end
        end
        clr = 1'b1;
        step();
        checks++; if (e !== 1'b1 || pk !== 1'b0) begin errors++; $display("FAIL tz_clr2: got e=%b pk=%b expected 1 0", e, pk); end
        clr = 1'b0;
        step();
        checks++; if (e !== 1'b0 || pk !== 1'b0) begin errors++; $display("FAIL tz_phase0: got e=%b pk=%b expected 0 0", e, pk); end
        step();
        checks++; if (e !== 1'b1 || pk !== 1'b1) begin errors++; $display("FAIL tz_phase1: got e=%b pk=%b expected 1 1", e, pk); end
        en = 1'b0; mode = 1'b1; pre = 4'd0;
        step();
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (tcr !== 7'd0 || e !== 1'b1 || pk !== 1'b1 || dir !== 1'b1) begin errors++; $display("FAIL tz_ud[%0d]: got tcr=%0d e=%b pk=%b dir=%b expected 0 1 1 1", k, tcr, e, pk, dir); end
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_updown();
        test_prescale();
        test_top_change();
        test_reset_mid();
        test_top_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
